mul8_dot_acc: RTL and testbench
===============================

Name: mul8_dot_acc

Overview:
- Sequential dot-product stage that consumes 8-bit operand pairs and accumulates their 16-bit products into a running sum.
- Computes each product with the existing combinational 8x8 multiplier (mul8_v4), then registers and accumulates it.
- Uses valid/ready handshakes on both input and output, so it can be streamed from an operand source and drained by a downstream consumer.
- Emits the sum, term count and a sticky overflow flag once the term marked last has been accumulated.

Parameters:
- ACC_W, 24: accumulator/result width in bits; must be >= 16.
- CNT_W, 8: term-counter width in bits.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  reset, asynchronous and active-high.
- clr  input  1  synchronous soft clear; aborts the current sequence.
- a  input  8  operand A, unsigned.
- b  input  8  operand B, unsigned.
- in_last  input  1  marks the final term of the current dot product.
- in_valid  input  1  operand pair presented.
- in_ready  output  1  block accepts an operand pair this cycle.
- out_sum  output  ACC_W  accumulated sum, mod 2^ACC_W.
- out_count  output  CNT_W  number of terms accumulated, mod 2^CNT_W.
- out_ovf  output  1  sticky: a carry out of ACC_W occurred in this sequence.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.

Behaviour:
- Reset (async, rst=1): state=ACC; p_vld=0, p_last=0, last_pend=0; acc=0, cnt=0, ovf=0. Outputs: out_valid=0, out_sum=0, out_count=0, out_ovf=0. in_ready=1 from the first edge after rst falls.
- State machine: states ACC (accepting terms) and HOLD (result presented).
- in_ready = (state==ACC) && !last_pend. It is combinational from registers only and never depends on in_valid.
- Accept: occurs when in_valid && in_ready at an edge. Then p_reg <= a*b (16 b, via mul8_v4), p_vld <= 1, p_last <= in_last, and last_pend <= in_last.
- Without an accept, p_vld <= 0.
- Accumulate: at any edge where p_vld=1:
  - {carry, acc} <= acc + zero-extended p_reg.
  - ovf <= ovf | carry.
  - cnt <= cnt + 1 (wraps).
- If p_last=1 at that edge: state <= HOLD; out_sum/out_count/out_ovf load the updated acc/cnt/ovf values; out_valid <= 1; last_pend <= 0.
- Throughput: one term per cycle while in ACC.
- Latency: last term accepted at edge T gives out_valid=1 after edge T+1.
- HOLD:
  - out_sum/out_count/out_ovf are held stable while out_valid=1 and out_ready=0.
  - On out_valid && out_ready: out_valid <= 0; acc, cnt, ovf <= 0; state <= ACC.
  - in_ready returns to 1 in the following cycle.
- Result outputs keep their last value after the handshake until the next result loads.
- Single-term sequence (in_last on the first term) is legal: out_count=1.
- A term in p_reg that is accumulated on the same edge as a new accept is legal; this is the normal pipelining case.
- clr=1 at an edge (overrides accept, accumulate and handshake):
  - p_vld, p_last, last_pend <= 0; acc, cnt, ovf <= 0.
  - out_valid <= 0; state <= ACC.
  - Result registers are unchanged.
- rst asserted mid-sequence or in HOLD: all state returns to reset values immediately; any in-flight result is lost.
- Width rules: the product is 16 b unsigned, zero-extended to ACC_W. No saturation; the sum wraps mod 2^ACC_W and ovf records that wrapping occurred.

Decomposition:
- Shared package: state encoding (ACC, HOLD) and the default widths (ACC_W=24, CNT_W=8) as constants.
- One sub-module instance: mul8_v4 for the product.
- FSM and accumulator stay in mul8_dot_acc; no further sub-module.

Test Plan:
- Single term a=255, b=255, last=1 -> out_valid after 2 edges; out_sum=65025 (0x00FE01), out_count=1, out_ovf=0.
- Back-to-back pairs (1,2),(3,4),(5,6),(7,8), last on the 4th, in_valid held high -> in_ready=1 for 4 cycles then 0; out_sum=100, out_count=4, out_ovf=0; out_valid exactly one edge after the 4th accept.
- Same sequence with out_ready=0 for 5 cycles -> out_valid, out_sum=100 and out_count=4 stable; in_ready=0 throughout. Handshake then gives in_ready=1 next cycle, and a new sequence (2,3),last gives out_sum=6, count=1 (accumulator cleared).
- 259 terms of (255,255) -> out_sum=64259 (16841475 mod 2^24), out_ovf=1, out_count=3 (259 mod 256). The next sequence starts with out_ovf=0.
- Accept 3 terms, pulse clr, then (10,10),last -> out_sum=100, out_count=1; no result produced for the aborted terms.
- Accept 2 terms, assert rst async mid-cycle -> out_valid=0, in_ready=0 while rst is high. After release, (4,4),last gives out_sum=16, out_count=1.

Source files
------------

// File: rtl/mul8_dot_acc_pkg.sv
// Shared definitions for the mul8_dot_acc dot-product stage: state encoding
// and default datapath widths.
package mul8_dot_acc_pkg;

   typedef enum logic {
      ST_ACC  = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   localparam int ACC_W_DEF  = 24;
   localparam int CNT_W_DEF  = 8;
   localparam int PROD_W     = 16;
   localparam int OPND_W     = 8;

endpackage

// File: rtl/mul8_v4.sv
// Combinational 8x8 unsigned multiplier built as a shift-and-add array of
// partial products; 16-bit result.
module mul8_v4 (
   input  logic [7:0]  a,
   input  logic [7:0]  b,
   output logic [15:0] p
);

   logic [15:0] pp [8];
   logic [15:0] sum;

   always_comb begin
      for (int i = 0; i < 8; i++) begin
         pp[i] = b[i] ? (16'(a) << i) : 16'd0;
      end
   end

   always_comb begin
      sum = 16'd0;
      for (int i = 0; i < 8; i++) begin
         sum = sum + pp[i];
      end
   end

   assign p = sum;

endmodule

// File: rtl/mul8_dot_acc.sv
// Streaming dot-product stage: registers each 8x8 product, accumulates it and
// presents sum/count/overflow once the term flagged last has been added.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   ACC   | accepting operand pairs and accumulating registered products
//   HOLD  | result presented on out_*; waiting for out_ready
module mul8_dot_acc
   import mul8_dot_acc_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic [7:0]       a,
   input  logic [7:0]       b,
   input  logic             in_last,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic [CNT_W-1:0] out_count,
   output logic             out_ovf,
   output logic             out_valid,
   input  logic             out_ready
);

   state_t state, state_nxt;

   logic              run;
   logic [PROD_W-1:0] prod;
   logic [PROD_W-1:0] p_reg;
   logic              p_vld;
   logic              p_last;
   logic              last_pend;
   logic [ACC_W-1:0]  acc;
   logic [CNT_W-1:0]  cnt;
   logic              ovf;

   logic              accept;
   logic              res_load;
   logic              res_take;
   logic [ACC_W:0]    sum_ext;
   logic [ACC_W-1:0]  acc_nxt;
   logic [CNT_W-1:0]  cnt_nxt;
   logic              ovf_nxt;

   mul8_v4 u_mul (
      .a (a),
      .b (b),
      .p (prod)
   );

   // sum_ext carries one extra bit so the wrap out of ACC_W is visible.
   assign sum_ext = {1'b0, acc} + {{(ACC_W - PROD_W + 1){1'b0}}, p_reg};
   assign acc_nxt = sum_ext[ACC_W-1:0];
   assign ovf_nxt = ovf | sum_ext[ACC_W];
   assign cnt_nxt = cnt + CNT_W'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_ACC;
      end else begin
         state <= state_nxt;
      end
   end

   // run holds in_ready low while rst is asserted and until the first edge after.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      accept    = 1'b0;
      res_load  = 1'b0;
      res_take  = 1'b0;
      case (state)
         ST_ACC: begin
            in_ready = run && !last_pend;
            accept   = in_valid && in_ready && !clr;
            res_load = p_vld && p_last && !clr;
            if (res_load) begin
               state_nxt = ST_HOLD;
            end
         end
         ST_HOLD: begin
            res_take = out_valid && out_ready && !clr;
            if (res_take) begin
               state_nxt = ST_ACC;
            end
         end
         default: state_nxt = ST_ACC;
      endcase
      if (clr) begin
         state_nxt = ST_ACC;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run       <= 1'b0;
         p_reg     <= '0;
         p_vld     <= 1'b0;
         p_last    <= 1'b0;
         last_pend <= 1'b0;
         acc       <= '0;
         cnt       <= '0;
         ovf       <= 1'b0;
         out_sum   <= '0;
         out_count <= '0;
         out_ovf   <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         run <= 1'b1;
         if (clr) begin
            p_vld     <= 1'b0;
            p_last    <= 1'b0;
            last_pend <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
         end else begin
            p_vld  <= accept;
            p_last <= accept && in_last;
            if (accept) begin
               p_reg     <= prod;
               last_pend <= in_last;
            end else if (res_load) begin
               last_pend <= 1'b0;
            end

            if (p_vld) begin
               acc <= acc_nxt;
               cnt <= cnt_nxt;
               ovf <= ovf_nxt;
            end else if (res_take) begin
               acc <= '0;
               cnt <= '0;
               ovf <= 1'b0;
            end

            if (res_load) begin
               out_sum   <= acc_nxt;
               out_count <= cnt_nxt;
               out_ovf   <= ovf_nxt;
               out_valid <= 1'b1;
            end else if (res_take) begin
               out_valid <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_mul8_dot_acc.sv
// Bench for mul8_dot_acc: vector table, directed corner sequences and random
// sequences checked against an arithmetic dot-product model.
module tb_mul8_dot_acc;

   localparam int ACC_W = 24;
   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             clr = 1'b0;
   logic [7:0]       a = '0;
   logic [7:0]       b = '0;
   logic             in_last = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [ACC_W-1:0] out_sum;
   logic [CNT_W-1:0] out_count;
   logic             out_ovf;
   logic             out_valid;
   logic             out_ready = 1'b0;

   int total = 0;
   int bad   = 0;

   mul8_dot_acc #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .a         (a),
      .b         (b),
      .in_last   (in_last),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_sum   (out_sum),
      .out_count (out_count),
      .out_ovf   (out_ovf),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      longint     exp_sum;
   } vec_t;

   vec_t tbl [6];

   task automatic check(input string nm, input longint act, input longint exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] ta, input logic [7:0] tb, input logic tl);
      int guard = 0;
      a = ta; b = tb; in_last = tl; in_valid = 1'b1;
      while (!in_ready && guard < 300) begin
         tick();
         guard++;
      end
      if (!in_ready) check("send_timeout", 0, 1);
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_result();
      int guard = 0;
      while (!out_valid && guard < 300) begin
         tick();
         guard++;
      end
      if (!out_valid) check("result_timeout", 0, 1);
   endtask

   task automatic take_result();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   longint model_total;
   int     model_len;
   int     gap;
   int     len;
   int     dly;
   logic [7:0] ra, rb;
   logic [ACC_W-1:0] saved_sum;

   initial begin
      tbl[0] = '{8'd255, 8'd255, 65025};
      tbl[1] = '{8'd0,   8'd0,   0};
      tbl[2] = '{8'd1,   8'd1,   1};
      tbl[3] = '{8'd0,   8'd255, 0};
      tbl[4] = '{8'd16,  8'd16,  256};
      tbl[5] = '{8'd200, 8'd3,   600};

      // reset state
      #3;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_sum", out_sum, 0);
      check("rst_out_count", out_count, 0);
      check("rst_out_ovf", out_ovf, 0);
      check("rst_in_ready", in_ready, 0);
      #9 rst = 1'b0;
      tick();
      check("post_rst_in_ready", in_ready, 1);

      // single-term table, including 2-edge latency
      foreach (tbl[i]) begin
         send(tbl[i].a, tbl[i].b, 1'b1);
         check("tbl_valid_early", out_valid, 0);
         check("tbl_in_ready_pend", in_ready, 0);
         tick();
         check("tbl_valid", out_valid, 1);
         check("tbl_sum", out_sum, tbl[i].exp_sum);
         check("tbl_count", out_count, 1);
         check("tbl_ovf", out_ovf, 0);
         take_result();
         check("tbl_valid_clear", out_valid, 0);
         check("tbl_in_ready_back", in_ready, 1);
      end

      // back-to-back pairs with a held result
      for (int i = 0; i < 4; i++) begin
         check("b2b_in_ready", in_ready, 1);
         a = 8'(2*i+1); b = 8'(2*i+2); in_last = (i == 3); in_valid = 1'b1;
         tick();
      end
      in_valid = 1'b0; in_last = 1'b0;
      check("b2b_in_ready_low", in_ready, 0);
      check("b2b_valid_early", out_valid, 0);
      tick();
      check("b2b_valid", out_valid, 1);
      for (int i = 0; i < 5; i++) begin
         check("hold_valid", out_valid, 1);
         check("hold_sum", out_sum, 100);
         check("hold_count", out_count, 4);
         check("hold_in_ready", in_ready, 0);
         tick();
      end
      check("hold_ovf", out_ovf, 0);
      take_result();
      check("hold_in_ready_back", in_ready, 1);
      send(8'd2, 8'd3, 1'b1);
      wait_result();
      check("after_hold_sum", out_sum, 6);
      check("after_hold_count", out_count, 1);
      take_result();

      // long sequence wrapping the accumulator and counter
      for (int i = 0; i < 259; i++) send(8'd255, 8'd255, i == 258);
      wait_result();
      check("wrap_sum", out_sum, 64259);
      check("wrap_count", out_count, 3);
      check("wrap_ovf", out_ovf, 1);
      take_result();
      send(8'd1, 8'd1, 1'b1);
      wait_result();
      check("wrap_next_ovf", out_ovf, 0);
      check("wrap_next_sum", out_sum, 1);
      take_result();
      saved_sum = out_sum;

      // soft clear aborts a sequence
      for (int i = 0; i < 3; i++) send(8'd9, 8'd9, 1'b0);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("clr_no_result", out_valid, 0);
         tick();
      end
      check("clr_keeps_sum", out_sum, longint'(saved_sum));
      send(8'd10, 8'd10, 1'b1);
      wait_result();
      check("clr_sum", out_sum, 100);
      check("clr_count", out_count, 1);
      take_result();

      // async reset mid-sequence
      send(8'd7, 8'd7, 1'b0);
      send(8'd8, 8'd8, 1'b0);
      #2 rst = 1'b1;
      #1;
      check("arst_valid", out_valid, 0);
      check("arst_in_ready", in_ready, 0);
      check("arst_sum", out_sum, 0);
      #14 rst = 1'b0;
      tick();
      send(8'd4, 8'd4, 1'b1);
      wait_result();
      check("arst_new_sum", out_sum, 16);
      check("arst_new_count", out_count, 1);
      take_result();

      // random sequences against the arithmetic model
      for (int s = 0; s < 40; s++) begin
         len = (s % 10 == 9) ? $urandom_range(200, 300) : $urandom_range(1, 8);
         model_total = 0;
         model_len = len;
         for (int t = 0; t < len; t++) begin
            gap = $urandom_range(0, 2);
            repeat (gap) tick();
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            if (s % 10 == 9) begin ra = 8'hFF; rb = 8'($urandom_range(240, 255)); end
            model_total += longint'(ra) * longint'(rb);
            send(ra, rb, t == len - 1);
         end
         wait_result();
         dly = $urandom_range(0, 3);
         repeat (dly) tick();
         check("rnd_valid", out_valid, 1);
         check("rnd_sum", out_sum, model_total % (64'd1 << ACC_W));
         check("rnd_count", out_count, model_len % (1 << CNT_W));
         check("rnd_ovf", out_ovf, (model_total >= (64'd1 << ACC_W)) ? 1 : 0);
         take_result();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
